// File: rtl/t_toggle_sequencer.sv
// t_toggle_sequencer: command-driven toggle generator for an N-bit T register.
// Produces one toggle vector per RUN cycle (up, down, gray step or load) and
// keeps a shadow copy of the register so the next vector can be derived.
module t_toggle_sequencer #(
    parameter int N      = 4,
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_mode,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic [N-1:0]      cmd_target,
    output logic [N-1:0]      t,
    output logic [N-1:0]      shadow_q,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [1:0] M_UP   = 2'b00;
    localparam logic [1:0] M_DN   = 2'b01;
    localparam logic [1:0] M_GRAY = 2'b10;
    localparam logic [1:0] M_LOAD = 2'b11;

    localparam logic [STEP_W-1:0] STEP_ONE = {{(STEP_W-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]      N_ONE    = {{(N-1){1'b0}}, 1'b1};

    state_t            state, nxt;
    logic [1:0]        mode_r;
    logic [STEP_W-1:0] remaining;
    logic [N-1:0]      target_r;

    logic [N-1:0] t_up, t_dn, t_gray, t_load;
    logic [N-1:0] gbin, gbin_inc;

    // Counter toggles: bit k flips when every lower bit is 1 (up) or 0 (down).
    assign t_up[0] = 1'b1;
    assign t_dn[0] = 1'b1;
    for (genvar k = 1; k < N; k++) begin : g_cnt
        assign t_up[k] = &shadow_q[k-1:0];
        assign t_dn[k] = ~|shadow_q[k-1:0];
    end

    // Gray decode as a suffix XOR so there is no combinational chain on gbin.
    for (genvar k = 0; k < N; k++) begin : g_gdec
        assign gbin[k] = ^shadow_q[N-1:k];
    end

    assign gbin_inc = gbin + N_ONE;
    assign t_gray   = (gbin_inc ^ (gbin_inc >> 1)) ^ shadow_q;
    assign t_load   = shadow_q ^ target_r;

    // Next-state and outputs; t is only non-zero while running.
    always_comb begin
        nxt       = state;
        t         = '0;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_mode == M_LOAD || cmd_steps != '0) nxt = RUN;
                    else                                       nxt = DONE;
                end
            end
            RUN: begin
                busy = 1'b1;
                case (mode_r)
                    M_UP:    t = t_up;
                    M_DN:    t = t_dn;
                    M_GRAY:  t = t_gray;
                    default: t = t_load;
                endcase
                if (mode_r == M_LOAD || remaining == STEP_ONE) nxt = DONE;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // State register and command latch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mode_r    <= '0;
            remaining <= '0;
            target_r  <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && cmd_valid) begin
                mode_r    <= cmd_mode;
                remaining <= cmd_steps;
                target_r  <= cmd_target;
            end else if (state == RUN) begin
                remaining <= remaining - STEP_ONE;
            end
        end
    end

    // Shadow mirrors the downstream T register: q <= q ^ t.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              shadow_q <= '0;
        else if (state == RUN) shadow_q <= shadow_q ^ t;
    end

endmodule

// File: tb/tb_t_toggle_sequencer.sv
// Randomized self-checking bench for t_toggle_sequencer against a value-level
// model: each step computes the next register value arithmetically and the
// expected toggle vector is old ^ new.
module tb_t_toggle_sequencer;

    localparam int N      = 4;
    localparam int STEP_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_mode;
    logic [STEP_W-1:0] cmd_steps;
    logic [N-1:0]      cmd_target;
    logic [N-1:0]      t;
    logic [N-1:0]      shadow_q;
    logic              busy;
    logic              done;

    int tests = 0;
    int fails = 0;
    logic [N-1:0] m_q;  // model of downstream register

    t_toggle_sequencer #(.N(N), .STEP_W(STEP_W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_steps(cmd_steps), .cmd_target(cmd_target),
        .t(t), .shadow_q(shadow_q), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [N-1:0] to_gray(input logic [N-1:0] x);
        return x ^ (x >> 1);
    endfunction

    // Inverse Gray by search over all codes.
    function automatic logic [N-1:0] from_gray(input logic [N-1:0] g);
        logic [N-1:0] r = '0;
        for (int i = 0; i < (1 << N); i++)
            if (to_gray(N'(i)) == g) r = N'(i);
        return r;
    endfunction

    function automatic logic [N-1:0] next_val(input logic [1:0] m, input logic [N-1:0] q,
                                              input logic [N-1:0] tgt);
        case (m)
            2'b00:   return q + 1'b1;
            2'b01:   return q - 1'b1;
            2'b10:   return to_gray(from_gray(q) + 1'b1);
            default: return tgt;
        endcase
    endfunction

    function automatic bit onehot(input logic [N-1:0] v);
        return v != '0 && (v & (v - 1'b1)) == '0;
    endfunction

    // Issue one command and follow it to completion. With intrude set, a
    // different command is held valid throughout busy and left on the bus.
    task automatic run_cmd(input logic [1:0] m, input int steps, input logic [N-1:0] tgt,
                           input bit intrude, input logic [1:0] im, input logic [N-1:0] itgt);
        int n, guard;
        logic [N-1:0] nq;
        guard = 0;
        while (!cmd_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_wait", {31'b0, cmd_ready}, 32'd1);
        cmd_valid  = 1'b1;
        cmd_mode   = m;
        cmd_steps  = STEP_W'(steps);
        cmd_target = tgt;
        chk("idle_t", 32'(t), 32'd0);
        @(negedge clk);
        if (intrude) begin
            cmd_mode   = im;
            cmd_steps  = 8'd3;
            cmd_target = itgt;
        end else begin
            cmd_valid = 1'b0;
        end
        n = (m == 2'b11) ? 1 : steps;
        for (int i = 0; i < n; i++) begin
            nq = next_val(m, m_q, tgt);
            chk("run_t", 32'(t), 32'(m_q ^ nq));
            chk("run_busy", {30'b0, busy, done}, 32'd2);
            chk("run_ready", {31'b0, cmd_ready}, 32'd0);
            if (m == 2'b10) chk("gray_onehot", {31'b0, onehot(t)}, 32'd1);
            m_q = nq;
            @(negedge clk);
            chk("run_shadow", 32'(shadow_q), 32'(m_q));
        end
        chk("done_pulse", {30'b0, busy, done}, 32'd3);
        chk("done_t", 32'(t), 32'd0);
        chk("done_ready", {31'b0, cmd_ready}, 32'd0);
        @(negedge clk);
        chk("post_idle", {29'b0, cmd_ready, busy, done}, 32'd4);
        chk("post_shadow", 32'(shadow_q), 32'(m_q));
    endtask

    initial begin
        logic [1:0] rm;
        logic [N-1:0] rt;
        int rs;
        rst = 1'b0; cmd_valid = 1'b0; cmd_mode = '0; cmd_steps = '0; cmd_target = '0;
        m_q = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_t", 32'(t), 32'd0);
        chk("rst_shadow", 32'(shadow_q), 32'd0);
        chk("rst_flags", {29'b0, cmd_ready, busy, done}, 32'd4);

        // Directed sequences from the plan.
        run_cmd(2'b00, 5, '0, 0, '0, '0);
        chk("up5_shadow", 32'(shadow_q), 32'h5);
        run_cmd(2'b01, 2, '0, 0, '0, '0);
        chk("dn2_shadow", 32'(shadow_q), 32'h3);
        run_cmd(2'b11, 0, 4'b0000, 0, '0, '0);
        run_cmd(2'b01, 1, '0, 0, '0, '0);
        chk("wrap_dn", 32'(shadow_q), 32'hF);
        run_cmd(2'b00, 1, '0, 0, '0, '0);
        chk("wrap_up", 32'(shadow_q), 32'h0);
        run_cmd(2'b10, 16, '0, 0, '0, '0);
        chk("gray16_shadow", 32'(shadow_q), 32'h0);
        run_cmd(2'b11, 0, 4'b0101, 0, '0, '0);
        run_cmd(2'b11, 0, 4'b1010, 0, '0, '0);
        chk("load_shadow", 32'(shadow_q), 32'hA);
        run_cmd(2'b11, 0, 4'b1010, 0, '0, '0);
        run_cmd(2'b00, 0, '0, 0, '0, '0);
        chk("steps0_shadow", 32'(shadow_q), 32'hA);

        // Intruding command held during busy, then taken in IDLE.
        run_cmd(2'b00, 4, '0, 1, 2'b11, 4'b0110);
        run_cmd(2'b11, 3, 4'b0110, 0, '0, '0);
        chk("intrude_load", 32'(shadow_q), 32'h6);

        // Reset in the middle of a run acts without an edge.
        cmd_valid = 1'b1; cmd_mode = 2'b00; cmd_steps = 8'd10;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy", {31'b0, busy}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_t", 32'(t), 32'd0);
        chk("mid_rst_shadow", 32'(shadow_q), 32'd0);
        chk("mid_rst_flags", {29'b0, cmd_ready, busy, done}, 32'd4);
        m_q = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Random commands.
        for (int k = 0; k < 40; k++) begin
            rm = 2'($urandom_range(0, 3));
            rt = N'($urandom);
            rs = $urandom_range(0, 20);
            if ($urandom_range(0, 4) == 0) begin
                run_cmd(rm, rs, rt, 1, 2'b11, rt);
                run_cmd(2'b11, 3, rt, 0, '0, '0);
            end else begin
                run_cmd(rm, rs, rt, 0, '0, '0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/t_toggle_sequencer.md
Name: t_toggle_sequencer

Overview:
- Upstream driver for the team's parameterised N-bit T flip-flop register (ports t/q/q_bar).
- Accepts commands over a valid/ready handshake and generates, cycle by cycle, the toggle vector t that drives the register through one of four patterns: binary up-count, binary down-count, Gray-code step, or direct load to a target.
- Keeps a shadow copy of the register contents (shadow_q). Both blocks sit in one clock/reset domain and clear to 0 together.

Parameters:
- N, 4, width of the toggle vector and shadow register (N >= 2).
- STEP_W, 8, width of the step-count field.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets immediately).
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command; high only in IDLE.
- cmd_mode  input  2  00 up, 01 down, 10 gray, 11 load.
- cmd_steps  input  STEP_W  number of toggle cycles; ignored for load.
- cmd_target  input  N  load value; used for mode 11 only.
- t  output  N  toggle vector to the T register; combinational from state/shadow.
- shadow_q  output  N  registered mirror of the downstream q.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when a command completes.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; shadow_q=0, remaining=0, mode register=0, target register=0.
  - t=0, done=0, busy=0, cmd_ready=1.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - t=0 and cmd_ready=1.
  - On an edge with cmd_valid=1, the block latches mode, steps and target.
  - It moves to RUN if (mode≠11 and steps≠0) or mode=11.
  - It moves to DONE if mode≠11 and steps=0.
- RUN:
  - t = f(mode, shadow_q), where f is defined below.
  - Each edge: shadow_q <= shadow_q ^ t; remaining <= remaining-1.
  - When remaining=1 (or mode=11), the next state is DONE.
  - Net effect: exactly `steps` non-zero toggle cycles, or exactly one cycle for load.
- DONE:
  - t=0, done=1 for exactly one cycle, then IDLE.
  - Earliest next command acceptance is the edge after DONE, i.e. command throughput is steps+2 cycles.
- cmd_valid outside IDLE is ignored; no queuing, no error.
- Toggle functions, with s = shadow_q:
  - up: t[0]=1; t[k] = AND of s[k-1:0].
  - down: t[0]=1; t[k] = AND of ~s[k-1:0].
  - gray: b = gray2bin(s); t = bin2gray(b+1 mod 2^N) ^ s. Result is always one-hot. If s is not a valid Gray value, it is decoded anyway; no special case.
  - load: t = s ^ target. Single cycle; t may be 0 if s already equals target, and the command still takes one RUN cycle.
- Wrap-around:
  - up from all-ones gives t = all-ones and shadow_q=0.
  - down from 0 gives t = all-ones and shadow_q = all-ones.
  - gray from bin2gray(2^N-1) wraps to 0.
- Arithmetic: remaining is STEP_W bits. cmd_steps = 2^STEP_W-1 is legal; no overflow handling is needed.
- Reset mid-operation: immediate return to the reset values. Any partial toggles already issued are discarded by the downstream register's own reset.
- Equivalence: shadow_q equals downstream q at every edge, given a shared reset and no other writer to t.

Test Plan:
- Reset check: rst=0 for 2 cycles, then release → t=0000, shadow_q=0000, cmd_ready=1, busy=0, done=0. Assert rst mid-RUN → all outputs return to reset values in the same cycle, without waiting for an edge.
- Up count: up, steps=5, from 0 → t sequence 0001,0011,0001,0111,0001; shadow_q=0101; done pulses once on the following cycle. Then down, steps=2 → t=0001,0111; shadow_q=0011.
- Wrap: from 0, down, steps=1 → t=1111, shadow_q=1111. Then up, steps=1 → t=1111, shadow_q=0000.
- Gray cycle: gray, steps=16, from 0 → every t is one-hot; shadow_q visits all 16 values once and returns to 0000; busy is high for 17 cycles.
- Load and edge cases:
  - shadow_q=0101, load target=1010 → a single t=1111 cycle, shadow_q=1010.
  - Load with target equal to shadow_q → t=0000 for one cycle, done still pulses.
  - up with steps=0 → no RUN cycle, done on the next cycle.
- Handshake: hold cmd_valid=1 with a different mode during busy → cmd_ready=0, the command is ignored, and the running sequence is unaltered. The command is accepted on the first IDLE edge.
